// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a show-ahead receive FIFO.
//
// The Rx line is double-flop synchronised and oversampled at 16 ticks per bit. Frames are
// start + DATA_BITS (MSB first) + optional parity + STOP_BITS. Error-free frames are pushed
// into the FIFO and errored frames are dropped. Rx_Error holds the status of the last frame.
//
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit value is the majority of the
// samples at ticks 6, 7 and 8. Without it, the single tick-7 sample is used.
//
// Ports:
//   SysClk        sole clock, rising edge
//   Rst           asynchronous active-low reset
//   Rx            asynchronous serial input, idle high
//   Read_Done     one-cycle pop strobe (ignored while empty)
//   Clear_Err     one-cycle strobe clearing FIFO_Overflow
//   Data_Out      FIFO head word (valid while FIFO_Empty = 0)
//   Data_Rdy      FIFO holds at least one word
//   FIFO_Empty    FIFO count is zero
//   FIFO_Full     FIFO count equals FIFO_DEPTH
//   FIFO_Overflow sticky: a word was dropped because the FIFO was full
//   RTS           FIFO count below FIFO_DEPTH-2
//   Rx_Error      last frame status: [0] break, [1] parity, [2] frame
//   Fifo_Count    current FIFO occupancy
module uart_rx_fifo #(
    parameter int unsigned SYSCLK_RATE = 100000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 2,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                        SysClk,
    input  logic                        Rst,
    input  logic                        Rx,
    input  logic                        Read_Done,
    input  logic                        Clear_Err,
    output logic [DATA_BITS-1:0]        Data_Out,
    output logic                        Data_Rdy,
    output logic                        FIFO_Empty,
    output logic                        FIFO_Full,
    output logic                        FIFO_Overflow,
    output logic                        RTS,
    output logic [2:0]                  Rx_Error,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);
    localparam int unsigned DIV_RAW   = (SYSCLK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreakWait} state_t;

    state_t               state;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick, sample, bit_val, bit_end, start_edge;
    logic [3:0]           tick_cnt, bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 all_zero, par_err, frm_err;
    logic                 done;
    logic [2:0]           done_err;

    // Synchroniser; rx_prev is the previous synchronised value for edge detection.
    // All three reset high so a line already low at reset release reads as a start edge.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == StIdle) && rx_prev && !rx_sync;

    // Tick divider restarts on the start edge so the sample points are centred on each bit.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick    = (div_cnt == DIV_W'(DIV - 1));
    assign bit_end = tick && (tick_cnt == 4'd15);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote;
    assign sample  = tick && (tick_cnt == 4'd8);
    assign bit_val = (vote[0] & vote[1]) | (vote[0] & rx_sync) | (vote[1] & rx_sync);
`else
    assign sample  = tick && (tick_cnt == 4'd7);
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            state    <= StIdle;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            all_zero <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            done     <= 1'b0;
            done_err <= '0;
            Rx_Error <= '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote     <= 2'b11;
`endif
        end else begin
            done <= 1'b0;
            if (done) begin
                Rx_Error <= done_err;
            end
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (tick && tick_cnt == 4'd6) vote[0] <= rx_sync;
            if (tick && tick_cnt == 4'd7) vote[1] <= rx_sync;
`endif
            if (tick && state != StIdle && state != StBreakWait) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            unique case (state)
                StIdle: begin
                    if (start_edge) begin
                        state    <= StStart;
                        tick_cnt <= '0;
                        all_zero <= 1'b1;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                    end
                end
                StStart: begin
                    if (sample && bit_val) begin
                        state <= StIdle;   // false start
                    end else if (bit_end) begin
                        state   <= StData;
                        bit_cnt <= '0;
                    end
                end
                StData: begin
                    if (sample) begin
                        shreg    <= {shreg[DATA_BITS-2:0], bit_val};
                        all_zero <= all_zero & ~bit_val;
                    end
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            stop_cnt <= 1'b0;
                            if (PARITY_MODE != 0) state <= StParity;
                            else                  state <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (sample) begin
                        par_err  <= bit_val != ((^shreg) ^ PAR_ODD);
                        all_zero <= all_zero & ~bit_val;
                    end
                    if (bit_end) begin
                        state    <= StStop;
                        stop_cnt <= 1'b0;
                    end
                end
                StStop: begin
                    if (sample) begin
                        if (stop_cnt == STOP_LAST) begin
                            // Frame completes at the mid-sample of the last stop bit.
                            done <= 1'b1;
                            if (all_zero && !bit_val) begin
                                done_err <= 3'b001;
                                state    <= StBreakWait;
                            end else begin
                                done_err <= {frm_err | ~bit_val, par_err, 1'b0};
                                state    <= StIdle;
                            end
                        end else begin
                            frm_err  <= frm_err | ~bit_val;
                            all_zero <= all_zero & ~bit_val;
                        end
                    end else if (bit_end) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                StBreakWait: begin
                    if (rx_sync) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Receive FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 push, pop, do_push, empty, full;

    assign push    = done && (done_err == 3'b000);
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop     = Read_Done && !empty;
    assign do_push = push && (!full || pop);   // a simultaneous pop frees the slot

    always_ff @(posedge SysClk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_Overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            // A new overflow wins over a coincident clear.
            if (push && full && !pop) FIFO_Overflow <= 1'b1;
            else if (Clear_Err)       FIFO_Overflow <= 1'b0;
        end
    end

    assign Data_Out   = empty ? '0 : mem[rd_ptr];
    assign Data_Rdy   = !empty;
    assign FIFO_Empty = empty;
    assign FIFO_Full  = full;
    assign RTS        = (count < (AW + 1)'(FIFO_DEPTH - 2));
    assign Fifo_Count = count;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter SYSCLK_RATE, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, data word width; legal range 5..9.
REQ-004 Parameter PARITY_MODE, default 1: 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 2; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 8; power of two, 4..256.
REQ-007 Port SysClk, in, 1, sole clock; all flops on its rising edge.
REQ-008 Port Rst, in, 1, asynchronous active-low reset.
REQ-009 Port Rx, in, 1, asynchronous serial line, idle high.
REQ-010 Port Read_Done, in, 1, one-cycle pop strobe.
REQ-011 Port Clear_Err, in, 1, one-cycle strobe that clears FIFO_Overflow.
REQ-012 Port Data_Out, out, DATA_BITS, FIFO head word (show-ahead).
REQ-013 Port Data_Rdy, out, 1, FIFO holds at least one word.
REQ-014 Port FIFO_Empty, out, 1, FIFO count is 0.
REQ-015 Port FIFO_Full, out, 1, FIFO count equals FIFO_DEPTH.
REQ-016 Port FIFO_Overflow, out, 1, sticky flag for a dropped word.
REQ-017 Port RTS, out, 1, high when FIFO count is below FIFO_DEPTH-2.
REQ-018 Port Rx_Error, out, 3, status of the last frame: [0] break, [1] parity, [2] frame.
REQ-019 Port Fifo_Count, out, $clog2(FIFO_DEPTH)+1, current occupancy.

Function
REQ-020 Rx shall pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-021 The tick generator shall pulse once every DIV = round(SYSCLK_RATE/(16*BAUD_RATE)) SysClk cycles, giving 16 ticks per bit.
REQ-022 The FSM shall have the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-023 IDLE: a high-to-low transition on the synchronised Rx shall enter START with the tick counter cleared.
REQ-024 START: at tick 7 a sampled 1 shall return to IDLE (false start, nothing recorded); a sampled 0 shall continue, and START shall exit to DATA after 16 ticks.
REQ-025 DATA: DATA_BITS bits, MSB first, each sampled at tick 7 of its bit.
REQ-026 PARITY: present only when PARITY_MODE != 0; even parity = XOR of the data bits, odd parity = its inverse; a mismatch sets the parity error.
REQ-027 STOP: each stop bit is sampled at tick 7; any 0 sets the frame error; the frame completes at the mid-sample of the last stop bit.
REQ-028 A frame whose data, parity and stop samples are all 0 shall report break (Rx_Error = 3'b001, other bits 0) and enter BREAK_WAIT until Rx reads 1, then go to IDLE.
REQ-029 Rx_Error shall update one cycle after frame completion and hold until the next frame completes.
REQ-030 An error-free frame shall be written to the FIFO one cycle after completion; an errored frame shall be discarded.
REQ-031 Data_Out shall be valid whenever FIFO_Empty = 0; after a Read_Done pop, the next word shall appear on the following cycle.
REQ-032 Read_Done while empty shall be ignored.
REQ-033 Push and pop in the same cycle shall both occur, including when the FIFO is full; the count is unchanged.
REQ-034 A push while full with no pop shall drop the word and set FIFO_Overflow.
REQ-035 FIFO_Overflow shall be cleared only by Clear_Err or reset; if Clear_Err and a new overflow occur in the same cycle, the flag shall be set.
REQ-036 Read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-037 Rst low shall immediately force: FSM = IDLE, counters = 0, FIFO empty, Data_Out = 0, Data_Rdy = 0, FIFO_Empty = 1, FIFO_Full = 0, FIFO_Overflow = 0, RTS = 1, Rx_Error = 0, Fifo_Count = 0, synchroniser flops = 1.
REQ-038 A reset asserted mid-frame shall abandon the frame; after reset deasserts, the line needs no idle time before the next start edge is accepted.

Configuration
REQ-039 With UART_RX_MAJORITY_VOTE_EN defined, every bit value shall be the majority of the samples at ticks 6, 7 and 8; without it, the single sample at tick 7 is used, and the START false-start check uses the same rule.

Verification
REQ-040 Frame 0xA5, even parity, 2 stop bits -> Data_Out = 0xA5, Data_Rdy = 1, Rx_Error = 000, Fifo_Count = 1.
REQ-041 Frame 0xAA with inverted parity -> Rx_Error = 010, FIFO_Empty stays 1.
REQ-042 Rx held low for 12 bit times, then high -> Rx_Error = 001, no write; the next frame 0x3C is received correctly.
REQ-043 Nine frames 0..8 with no reads (depth 8) -> RTS low after 6 words, FIFO_Full = 1 after 8, FIFO_Overflow = 1; eight reads return 0..7; Clear_Err clears FIFO_Overflow.
REQ-044 4-tick low glitch on Rx -> no frame, Rx_Error unchanged, FIFO_Empty = 1.
REQ-045 Rst low during DATA of a frame -> all outputs take their reset values; the following frame 0x5A is received correctly.
